tape_prefetch: RTL and testbench
================================

# tape_prefetch

Byte-fetch front end for the tape player. It sits directly upstream of the tape block: it generates the `rd_en` read-slot strobe, services the tape's `rd`/`addr` requests, and returns the byte on `din`. Bytes come from a generic single-outstanding memory read port (SDRAM arbiter side) through a small sequential prefetch FIFO. This hides memory latency for linear TAP/TZX/CSW streaming and supports random jumps (block prev/next, TZX loops).

## Interface
Parameters:
- `ADDR_W`, 25, byte address width; addresses wrap modulo 2^ADDR_W.
- `DEPTH`, 8, prefetch FIFO depth in bytes; power of 2, ≥2.
- `SLOT`, 4, minimum `rd_en` high cycles per slot, ≥1.
- `GAP`, 2, `rd_en` low cycles between slots, ≥2.

Ports:
- `clk_sys` in 1: system clock, sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `tape_ready` in 1: tape image present; low flushes the FIFO.
- `rd_en` out 1: read slot strobe to the tape block.
- `rd` in 1: tape read request; only meaningful while `rd_en`=1.
- `addr` in ADDR_W: byte address requested, sampled with `rd`.
- `din` out 8: returned byte, valid from the cycle `rd_en` falls until the next slot completes.
- `mem_req` out 1: memory read request, level.
- `mem_addr` out ADDR_W: memory address, stable while `mem_req`=1.
- `mem_ack` in 1: one-cycle pulse; `mem_data` valid in the same cycle.
- `mem_data` in 8: memory read data.
- `busy` out 1: high while a miss is stretching a slot.

## Operation
- FIFO state: `head` (address of oldest byte), `count` (0..DEPTH), `fetch_addr` = head+count+pending.
- Slot FSM:
  - GAP: `rd_en`=0 for GAP cycles, then SLOT.
  - SLOT: `rd_en`=1. On the first cycle with `rd`=1, latch `addr`.
    - Hit (`addr`==`head`, `count`>0): load `din` with the FIFO byte, pop, go to GAP next cycle.
    - Miss: flush, set `head`=`fetch_addr`=`addr`, go to WAIT.
    - If no `rd` after SLOT cycles: go to GAP; `din` and FIFO are unchanged.
  - WAIT: `rd_en` stays 1 and `busy`=1 until the byte for `head` is in the FIFO. Then load `din`, pop, go to GAP.
- Prefetch: when `mem_req`=0, `count`+pending<DEPTH and `tape_ready`=1, issue `mem_req` with `mem_addr`=`fetch_addr`. On `mem_ack`, push `mem_data` (unless discard is set), `fetch_addr`+1 (wraps), and drop `mem_req` for at least one cycle.
- Only one request is outstanding at a time. A flush (miss or `tape_ready`=0) while a request is pending sets `discard`. `mem_req` is held until `mem_ack`, that response is dropped, and only then is a request issued for the new `head`.
- `tape_ready`=0: flush, `count`=0, the slot FSM keeps cycling, and no new prefetch is issued.
- A simultaneous `mem_ack` and hit-pop in the same cycle are both applied: `count` is unchanged.
- FIFO full: no request is issued; data is never overwritten.

## Timing
- Reset values: `rd_en`=0, `din`=8'hFF, `mem_req`=0, `mem_addr`=0, `busy`=0, `count`=0, `discard`=0, FSM=GAP.
- Reset mid-operation: any pending memory request is abandoned (`mem_req` drops). The memory side must tolerate a late `mem_ack`; one arriving within GAP cycles after reset is ignored.
- Hit latency: `rd` sampled in cycle N → `din` valid and `rd_en`=0 in cycle N+1. The tape block captures the byte on that falling edge.
- Miss latency: memory latency plus 1 cycle from `rd`, plus any discard drain.
- `din` changes only in the cycle `rd_en` deasserts.
- Steady-state throughput: one byte per SLOT+GAP cycles when memory latency < (SLOT+GAP)·DEPTH.

## Configuration
- `TAPE_PREFETCH_EN` defined: behaviour as above, with a DEPTH-byte lookahead FIFO.
- `TAPE_PREFETCH_EN` undefined: no FIFO and no lookahead.
  - Every `rd` is a miss and triggers exactly one memory request for `addr`.
  - The slot is stretched in WAIT until `mem_ack`.
  - `mem_req` is never issued outside a slot.
  - DEPTH is ignored. Interface and reset values are identical.

## Test plan
- Linear stream: memory latency 3, `mem[a]`=a[7:0]^8'h5A, tape reads 0..31 → every `din` correct. From byte 2 onward every slot is a hit with `rd_en` high exactly SLOT cycles; no `busy`.
- Jump: read 0x00, 0x01, then 0x100 → miss: `busy`=1, `rd_en` stretched, `din`=8'h5A, next `mem_addr` issued=0x101. Then 0x101 is a hit.
- Flush during pending request: `tape_ready` drops while `mem_req`=1 → `mem_ack` data is discarded. After `tape_ready` rises, the first read of 0x000 fetches fresh data.
- Wrap: read 0x1FFFFFE, 0x1FFFFFF, 0x0000000 → prefetch `mem_addr` wraps to 0. The third read is a hit.
- Idle slot: no `rd` during slot → `rd_en` high SLOT cycles, `din` held at its prior value, `count` unchanged.
- Reset in WAIT: assert `rst_n`=0 → next cycle `rd_en`=0, `mem_req`=0, `din`=8'hFF, `busy`=0. A late `mem_ack` pushes nothing.

Source files
------------

// File: rtl/tape_prefetch.sv
// -----------------------------------------------------------------------------
// tape_prefetch
//
// Byte-fetch front end for the tape player. Generates the rd_en read-slot
// strobe for the tape block, answers its rd/addr requests with a byte on din,
// and fetches bytes from a single-outstanding memory read port.
//
// Build option: TAPE_PREFETCH_EN
//   defined   - a DEPTH-byte sequential lookahead FIFO hides memory latency;
//               consecutive addresses hit, any other address flushes and
//               restarts the stream at that address.
//   undefined - no FIFO: every rd issues exactly one memory request for addr
//               and the slot is stretched until mem_ack.
//
// Ports
//   clk_sys    in   system clock
//   rst_n      in   synchronous active-low reset
//   tape_ready in   tape image present; low flushes the FIFO, stops prefetch
//   rd_en      out  read slot strobe: low GAP cycles, high >= SLOT cycles
//   rd         in   read request, meaningful only while rd_en=1
//   addr       in   byte address, sampled with rd
//   din        out  returned byte, updated only in the cycle rd_en falls
//   mem_req    out  memory read request (level, held until mem_ack)
//   mem_addr   out  memory byte address, stable while mem_req=1
//   mem_ack    in   one-cycle response strobe, mem_data valid with it
//   mem_data   in   memory read data
//   busy       out  high while a miss stretches the slot
// -----------------------------------------------------------------------------
module tape_prefetch #(
    parameter int ADDR_W = 25,
    parameter int DEPTH  = 8,
    parameter int SLOT   = 4,
    parameter int GAP    = 2
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              tape_ready,
    output logic              rd_en,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        din,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy
);

    localparam int TMR_MAX = (SLOT > GAP) ? SLOT : GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_SLOT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n;
    logic [TMR_W-1:0]    tmr_r;
    logic [TMR_W-1:0]    tmr_n;
    logic [7:0]          din_r;
    logic [7:0]          din_n;
    logic                rd_en_r;
    logic                busy_r;
    logic                mem_req_r;
    logic                mem_req_n;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic                ack_s;
    logic                issue_s;

    // Late acks (after a reset abandoned the request) have mem_req_r=0 and are ignored.
    assign ack_s = mem_ack & mem_req_r;

`ifdef TAPE_PREFETCH_EN
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Bytes are stored at the low bits of their own address, so the read
    // index is head_r and the write index is the address being fetched.
    logic [7:0]          fifo_mem [DEPTH];
    logic [ADDR_W-1:0]   head_r;
    logic [ADDR_W-1:0]   head_n;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_n;
    logic [ADDR_W-1:0]   fetch_addr_r;
    logic [ADDR_W-1:0]   fetch_addr_n;
    logic                discard_r;
    logic                discard_n;
    logic                armed_r;
    logic                take_s;
    logic                miss_s;
    logic                flush_s;
    logic                push_s;
    logic [7:0]          fifo_byte_s;

    assign fifo_byte_s = fifo_mem[head_r[IDX_W-1:0]];
`else
    logic                unused_s;

    assign unused_s = tape_ready ^ 1'(DEPTH);
`endif

    // Slot FSM: next state, slot/gap timer and returned byte.
    always_comb begin
        state_n = state_r;
        tmr_n   = tmr_r;
        din_n   = din_r;
`ifdef TAPE_PREFETCH_EN
        take_s  = 1'b0;
        miss_s  = 1'b0;
`else
        issue_s = 1'b0;
`endif
        case (state_r)
            ST_GAP: begin
                if (tmr_r == TMR_W'(GAP - 1)) begin
                    state_n = ST_SLOT;
                    tmr_n   = {TMR_W{1'b0}};
                end else begin
                    tmr_n = tmr_r + TMR_W'(1);
                end
            end
            ST_SLOT: begin
                if (rd) begin
                    tmr_n = {TMR_W{1'b0}};
`ifdef TAPE_PREFETCH_EN
                    if ((addr == head_r) && (count_r != {CNT_W{1'b0}})) begin
                        take_s  = 1'b1;
                        din_n   = fifo_byte_s;
                        state_n = ST_GAP;
                    end else begin
                        // addr==head with an empty FIFO is just a stream
                        // that has not caught up yet: wait without flushing.
                        miss_s  = (addr != head_r);
                        state_n = ST_WAIT;
                    end
`else
                    issue_s = 1'b1;
                    state_n = ST_WAIT;
`endif
                end else if (tmr_r == TMR_W'(SLOT - 1)) begin
                    state_n = ST_GAP;
                    tmr_n   = {TMR_W{1'b0}};
                end else begin
                    tmr_n = tmr_r + TMR_W'(1);
                end
            end
            ST_WAIT: begin
`ifdef TAPE_PREFETCH_EN
                if (count_r != {CNT_W{1'b0}}) begin
                    take_s  = 1'b1;
                    din_n   = fifo_byte_s;
                    state_n = ST_GAP;
                end else if (!tape_ready) begin
                    // Image removed: nothing will arrive, release the slot.
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_WAIT;
                end
`else
                if (ack_s) begin
                    din_n   = mem_data;
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_WAIT;
                end
`endif
            end
            default: begin
                state_n = ST_GAP;
                tmr_n   = {TMR_W{1'b0}};
            end
        endcase
    end

`ifdef TAPE_PREFETCH_EN
    // Prefetch control: FIFO occupancy, fetch pointer, discard and request.
    always_comb begin
        flush_s      = miss_s | ~tape_ready;
        push_s       = ack_s & ~discard_r & ~flush_s;
        issue_s      = ~mem_req_r & tape_ready & armed_r & ~flush_s &
                       (count_r < CNT_W'(DEPTH));
        mem_req_n    = mem_req_r;
        mem_addr_n   = mem_addr_r;
        if (miss_s) begin
            head_n = addr;
        end else begin
            head_n = head_r + ADDR_W'(take_s);
        end
        if (flush_s) begin
            count_n      = {CNT_W{1'b0}};
            fetch_addr_n = head_n;
        end else if (issue_s) begin
            count_n      = count_r + CNT_W'(push_s) - CNT_W'(take_s);
            fetch_addr_n = fetch_addr_r + ADDR_W'(1);
        end else begin
            count_n      = count_r + CNT_W'(push_s) - CNT_W'(take_s);
            fetch_addr_n = fetch_addr_r;
        end
        if (ack_s) begin
            mem_req_n = 1'b0;
        end else if (issue_s) begin
            mem_req_n  = 1'b1;
            mem_addr_n = fetch_addr_r;
        end else begin
            mem_req_n = mem_req_r;
        end
        // A flush with a request in flight: that response belongs to the old stream.
        if (ack_s) begin
            discard_n = 1'b0;
        end else if (flush_s && mem_req_r) begin
            discard_n = 1'b1;
        end else begin
            discard_n = discard_r;
        end
    end

    // Prefetch state registers.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            head_r       <= {ADDR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            fetch_addr_r <= {ADDR_W{1'b0}};
            discard_r    <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            head_r       <= head_n;
            count_r      <= count_n;
            fetch_addr_r <= fetch_addr_n;
            discard_r    <= discard_n;
            // Prefetch stays off for the first gap so a late ack from before
            // reset can never be taken for a fresh request.
            armed_r      <= armed_r | (state_n == ST_SLOT);
        end
    end

    // FIFO storage write on an accepted memory response.
    always_ff @(posedge clk_sys) begin
        if (push_s) begin
            fifo_mem[mem_addr_r[IDX_W-1:0]] <= mem_data;
        end
    end
`else
    // Direct request control: one request per rd, held until its ack.
    always_comb begin
        mem_req_n  = mem_req_r;
        mem_addr_n = mem_addr_r;
        if (ack_s) begin
            mem_req_n = 1'b0;
        end else if (issue_s) begin
            mem_req_n  = 1'b1;
            mem_addr_n = addr;
        end else begin
            mem_req_n = mem_req_r;
        end
    end
`endif

    // Slot FSM, output and memory request registers.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_r    <= ST_GAP;
            tmr_r      <= {TMR_W{1'b0}};
            din_r      <= 8'hFF;
            rd_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_n;
            tmr_r      <= tmr_n;
            din_r      <= din_n;
            rd_en_r    <= (state_n != ST_GAP);
            busy_r     <= (state_n == ST_WAIT);
            mem_req_r  <= mem_req_n;
            mem_addr_r <= mem_addr_n;
        end
    end

    assign rd_en    = rd_en_r;
    assign din      = din_r;
    assign busy     = busy_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_tape_prefetch.sv
// -----------------------------------------------------------------------------
// tb_tape_prefetch
//
// Directed bench for tape_prefetch. A behavioural memory answers each request
// after LAT cycles with addr[7:0]^key (key captured when the request is seen).
// Every tape read pushes its expected byte onto a scoreboard queue; the byte
// is popped and compared when rd_en falls.
// -----------------------------------------------------------------------------
module tb_tape_prefetch;

    localparam int ADDR_W = 25;
    localparam int DEPTH  = 8;
    localparam int SLOT   = 4;
    localparam int GAP    = 2;
    localparam int LAT    = 3;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic              tape_ready;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic [7:0]        din;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack  = 1'b0;
    logic [7:0]        mem_data = 8'h00;
    logic              busy;

    int                n_cmp  = 0;
    int                n_fail = 0;
    logic [7:0]        key      = 8'h5A;
    logic [7:0]        exp_q[$];
    logic [7:0]        last_exp = 8'hFF;

    // memory model state
    logic              m_active = 1'b0;
    int                m_cnt    = 0;
    logic [7:0]        m_data   = 8'h00;

    // request monitor state
    logic              req_prev    = 1'b0;
    logic [ADDR_W-1:0] last_issued = '0;
    logic              watch_arm   = 1'b0;
    logic              saw_zero    = 1'b0;

    tape_prefetch #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SLOT   (SLOT),
        .GAP    (GAP)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .tape_ready (tape_ready),
        .rd_en      (rd_en),
        .rd         (rd),
        .addr       (addr),
        .din        (din),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory with fixed latency LAT from the first cycle mem_req is seen high.
    always @(posedge clk_sys) begin
        mem_ack <= 1'b0;
        if (m_active) begin
            if (m_cnt == 0) begin
                mem_ack  <= 1'b1;
                mem_data <= m_data;
                m_active <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mem_req && !mem_ack) begin
            m_active <= 1'b1;
            m_cnt    <= LAT - 2;
            m_data   <= mem_addr[7:0] ^ key;
        end
    end

    // Record the address of each newly raised request.
    always @(posedge clk_sys) begin
        req_prev <= mem_req;
        if (!watch_arm) begin
            saw_zero <= 1'b0;
        end else if (mem_req && !req_prev && (mem_addr == '0)) begin
            saw_zero <= 1'b1;
        end
        if (mem_req && !req_prev) begin
            last_issued <= mem_addr;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_en(input logic lvl);
        int n;
        n = 0;
        while (rd_en !== lvl && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("rd_en_wait", {31'd0, rd_en}, {31'd0, lvl});
    endtask

    // One tape read issued 'late' cycles into the slot; returns high-time and busy cycles.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int late,
                           output int hi, output int bsy);
        int n;
        logic [7:0] e;
        wait_rd_en(1'b0);
        wait_rd_en(1'b1);
        hi  = 1;
        bsy = 0;
        for (int k = 0; k < late; k++) begin
            @(posedge clk_sys); #1;
            hi++;
        end
        rd   = 1'b1;
        addr = a;
        exp_q.push_back(a[7:0] ^ key);
        @(posedge clk_sys); #1;
        rd = 1'b0;
        n = 0;
        while (rd_en === 1'b1 && n < 200) begin
            if (busy === 1'b1) bsy++;
            hi++;
            @(posedge clk_sys); #1;
            n++;
        end
        chk("slot_end", {31'd0, rd_en}, 32'd0);
        e = exp_q.pop_front();
        last_exp = e;
        chk("din", {24'd0, din}, {24'd0, e});
    endtask

    initial begin
        int hi;
        int b;
        int n;
        int rises;
        logic prev;

        rst_n      = 1'b0;
        tape_ready = 1'b1;
        rd         = 1'b0;
        addr       = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_rd_en",    {31'd0, rd_en},   32'd0);
        chk("rst_din",      {24'd0, din},     32'h0000_00FF);
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_busy",     {31'd0, busy},    32'd0);
        rst_n = 1'b1;

        // linear stream, rd on the last slot cycle
        for (int i = 0; i < 32; i++) begin
            do_read(ADDR_W'(i), SLOT - 1, hi, b);
`ifdef TAPE_PREFETCH_EN
            if (i >= 2) begin
                chk("linear_slot_len", hi, SLOT);
                chk("linear_no_busy", b, 0);
            end
`endif
        end

        // jump
        do_read(ADDR_W'(0), 0, hi, b);
        do_read(ADDR_W'(1), 0, hi, b);
        do_read(ADDR_W'(32'h100), 0, hi, b);
        chk("jump_busy_seen", {31'd0, (b > 0)}, 32'd1);
        chk("jump_stretched", {31'd0, (hi > 1)}, 32'd1);
        chk("jump_din", {24'd0, din}, 32'h0000_005A);
`ifdef TAPE_PREFETCH_EN
        repeat (2) @(posedge clk_sys);
        #1;
        chk("jump_next_issue", {7'd0, last_issued}, 32'h101);
`endif
        do_read(ADDR_W'(32'h101), 0, hi, b);
`ifdef TAPE_PREFETCH_EN
        chk("jump_then_hit_busy", b, 0);
        chk("jump_then_hit_len", hi, 1);
`endif

        // address wrap
        watch_arm = 1'b1;
        do_read(ADDR_W'(32'h1FF_FFFE), SLOT - 1, hi, b);
        do_read(ADDR_W'(32'h1FF_FFFF), SLOT - 1, hi, b);
        do_read(ADDR_W'(0), SLOT - 1, hi, b);
        chk("wrap_req_zero", {31'd0, saw_zero}, 32'd1);
`ifdef TAPE_PREFETCH_EN
        chk("wrap_hit_busy", b, 0);
        chk("wrap_hit_len", hi, SLOT);
`endif
        watch_arm = 1'b0;

        // idle slot
        wait_rd_en(1'b0);
        wait_rd_en(1'b1);
        hi = 0;
        n  = 0;
        while (rd_en === 1'b1 && n < 200) begin
            hi++;
            @(posedge clk_sys); #1;
            n++;
        end
        chk("idle_slot_len", hi, SLOT);
        chk("idle_din_held", {24'd0, din}, {24'd0, last_exp});
        do_read(ADDR_W'(1), SLOT - 1, hi, b);
`ifdef TAPE_PREFETCH_EN
        chk("idle_then_hit_busy", b, 0);
`endif

        // flush while a request is in flight
`ifdef TAPE_PREFETCH_EN
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("flush_req_pending", {31'd0, mem_req}, 32'd1);
`endif
        key        = 8'hC3;
        tape_ready = 1'b0;
        rises      = 0;
        prev       = rd_en;
        repeat (20) begin
            @(posedge clk_sys); #1;
            if (rd_en && !prev) rises++;
            prev = rd_en;
        end
        chk("slots_while_not_ready", {31'd0, (rises > 0)}, 32'd1);
`ifdef TAPE_PREFETCH_EN
        chk("no_prefetch_not_ready", {31'd0, mem_req}, 32'd0);
`endif
        tape_ready = 1'b1;
        do_read(ADDR_W'(2), SLOT - 1, hi, b);
        do_read(ADDR_W'(0), SLOT - 1, hi, b);

        // reset while a slot is stretched
        wait_rd_en(1'b0);
        wait_rd_en(1'b1);
        rd   = 1'b1;
        addr = ADDR_W'(32'h2A5);
        @(posedge clk_sys); #1;
        rd = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("wait_req_up", {31'd0, mem_req}, 32'd1);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk_sys); #1;
        chk("wrst_rd_en",   {31'd0, rd_en},   32'd0);
        chk("wrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("wrst_din",     {24'd0, din},     32'h0000_00FF);
        chk("wrst_busy",    {31'd0, busy},    32'd0);
        rst_n = 1'b1;
        do_read(ADDR_W'(0), 0, hi, b);
        do_read(ADDR_W'(32'h3C7), 0, hi, b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
